// File: rtl/mult_col_accum.sv
// Product-scanning column accumulator: sums 2*RADIX-bit partial products per column,
// emits one RADIX-bit product word per column end, then the top carry word on completion.
module mult_col_accum #(
    parameter int RADIX = 32,
    parameter int GUARD = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 zeroize,
    input  logic [2*RADIX-1:0]   p_i,
    input  logic                 p_valid_i,
    input  logic                 col_last_i,
    input  logic                 op_last_i,
    output logic                 ready_o,
    output logic [RADIX-1:0]     word_o,
    output logic                 word_valid_o,
    output logic                 done_o,
    output logic                 ovf_o
);

    localparam int AW = 2*RADIX + GUARD;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_s1_valid;
    logic [2*RADIX-1:0]   r_s1_p;
    logic                 r_s1_col_last;
    logic                 r_s1_op_last;

    logic [AW-1:0]        r_acc;
    logic [RADIX-1:0]     r_word;
    logic                 r_word_valid;
    logic                 r_done;
    logic                 r_ovf;
    logic                 r_new_op;

    logic                 w_accept;
    logic [AW:0]          w_sum_ext;
    logic [AW-1:0]        w_sum;
    logic                 w_carry;
    logic                 w_col_end;
    logic                 w_hi_nz;

    logic [AW-1:0]        w_acc_next;
    logic [RADIX-1:0]     w_word_next;
    logic                 w_word_valid_next;
    logic                 w_done_next;
    logic                 w_ovf_next;
    logic                 w_new_op_next;

    // Ready stays low through the done cycle so the next operation starts cleanly.
    assign ready_o      = (r_state == ACCUM) && !r_done;
    assign word_o       = r_word;
    assign word_valid_o = r_word_valid;
    assign done_o       = r_done;
    assign ovf_o        = r_ovf;

    assign w_accept  = p_valid_i && ready_o;
    assign w_sum_ext = {1'b0, r_acc} + {{(GUARD+1){1'b0}}, r_s1_p};
    assign w_sum     = w_sum_ext[AW-1:0];
    assign w_carry   = w_sum_ext[AW];
    assign w_col_end = r_s1_col_last || r_s1_op_last;
    assign w_hi_nz   = |r_acc[AW-1:RADIX];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && op_last_i) w_state_next = DRAIN;
            DRAIN:   if (r_s1_valid && r_s1_op_last) w_state_next = FLUSH;
            FLUSH:   w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_comb begin
        w_acc_next        = r_acc;
        w_word_next       = r_word;
        w_word_valid_next = 1'b0;
        w_done_next       = 1'b0;
        w_ovf_next        = r_ovf;
        w_new_op_next     = r_new_op;

        // The sticky flag survives done_o and is cleared by the next operation's first input.
        if (w_accept && r_new_op) begin
            w_ovf_next    = 1'b0;
            w_new_op_next = 1'b0;
        end

        if (r_state == FLUSH) begin
            w_word_next       = r_acc[RADIX-1:0];
            w_word_valid_next = 1'b1;
            w_done_next       = 1'b1;
            w_acc_next        = '0;
            w_new_op_next     = 1'b1;
            if (w_hi_nz) w_ovf_next = 1'b1;
        end else if (r_s1_valid) begin
            if (w_carry) w_ovf_next = 1'b1;
            if (w_col_end) begin
                w_word_next       = w_sum[RADIX-1:0];
                w_word_valid_next = 1'b1;
                w_acc_next        = w_sum >> RADIX;
            end else begin
                w_acc_next        = w_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ACCUM;
            r_s1_valid    <= 1'b0;
            r_s1_p        <= '0;
            r_s1_col_last <= 1'b0;
            r_s1_op_last  <= 1'b0;
            r_acc         <= '0;
            r_word        <= '0;
            r_word_valid  <= 1'b0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_new_op      <= 1'b1;
        end else if (zeroize) begin
            r_state       <= ACCUM;
            r_s1_valid    <= 1'b0;
            r_s1_p        <= '0;
            r_s1_col_last <= 1'b0;
            r_s1_op_last  <= 1'b0;
            r_acc         <= '0;
            r_word        <= '0;
            r_word_valid  <= 1'b0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_new_op      <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_s1_valid    <= w_accept;
            if (w_accept) begin
                r_s1_p        <= p_i;
                r_s1_col_last <= col_last_i;
                r_s1_op_last  <= op_last_i;
            end
            r_acc         <= w_acc_next;
            r_word        <= w_word_next;
            r_word_valid  <= w_word_valid_next;
            r_done        <= w_done_next;
            r_ovf         <= w_ovf_next;
            r_new_op      <= w_new_op_next;
        end
    end

endmodule

// File: tb/tb_mult_col_accum.sv
// Directed bench for mult_col_accum: multi-column product, latency, overflow, drop, zeroize, reset.
module tb_mult_col_accum;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        zeroize;
    logic [63:0] p_i;
    logic        p_valid_i;
    logic        col_last_i;
    logic        op_last_i;
    logic        ready_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        done_o;
    logic        ovf_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] wq[$];
    int          done_cnt;
    int          done_idx;

    localparam logic [63:0] P_SQ  = 64'hFFFFFFFE_00000001;
    localparam logic [63:0] P_ONE = 64'hFFFFFFFF_FFFFFFFF;

    always #5 clk = ~clk;

    mult_col_accum #(.RADIX(32), .GUARD(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .zeroize      (zeroize),
        .p_i          (p_i),
        .p_valid_i    (p_valid_i),
        .col_last_i   (col_last_i),
        .op_last_i    (op_last_i),
        .ready_o      (ready_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .done_o       (done_o),
        .ovf_o        (ovf_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (word_valid_o) wq.push_back(word_o);
        if (done_o) begin
            done_cnt++;
            done_idx = wq.size() - 1;
        end
    endtask

    task automatic set_idle();
        p_valid_i  = 1'b0;
        p_i        = '0;
        col_last_i = 1'b0;
        op_last_i  = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic cl, input logic ol);
        p_valid_i  = v;
        p_i        = p;
        col_last_i = cl;
        op_last_i  = ol;
        tick();
    endtask

    task automatic clear_log();
        wq.delete();
        done_cnt = 0;
        done_idx = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        zeroize = 1'b0;
        set_idle();
        clear_log();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_ready", ready_o, 1);
        chk("rst_word", word_o, 0);
        chk("rst_wvalid", word_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", ovf_o, 0);
        $display("txn reset: ready=%0d word=%0h", ready_o, word_o);

        // 2x2 squaring of 0xFFFFFFFF_FFFFFFFF, back-to-back inputs
        clear_log();
        drive(1, P_SQ, 1, 0);
        drive(1, P_SQ, 0, 0);
        drive(1, P_SQ, 1, 0);
        drive(1, P_SQ, 1, 1);
        set_idle();
        repeat (5) tick();
        chk("sq_count", wq.size(), 4);
        chk("sq_w0", wq_at(0), 32'h00000001);
        chk("sq_w1", wq_at(1), 32'h00000000);
        chk("sq_w2", wq_at(2), 32'hFFFFFFFE);
        chk("sq_w3", wq_at(3), 32'hFFFFFFFF);
        chk("sq_done_cnt", done_cnt, 1);
        chk("sq_done_idx", done_idx, 3);
        chk("sq_ovf", ovf_o, 0);
        $display("txn square: words=%0d done_idx=%0d", wq.size(), done_idx);

        // single product, exact cycle timing
        clear_log();
        drive(1, 64'h12345678_9ABCDEF0, 1, 1);
        set_idle();
        chk("t1_ready", ready_o, 0);
        chk("t1_wvalid", word_valid_o, 0);
        tick();
        chk("t2_wvalid", word_valid_o, 1);
        chk("t2_word", word_o, 32'h9ABCDEF0);
        chk("t2_done", done_o, 0);
        chk("t2_ready", ready_o, 0);
        tick();
        chk("t3_wvalid", word_valid_o, 1);
        chk("t3_word", word_o, 32'h12345678);
        chk("t3_done", done_o, 1);
        chk("t3_ready", ready_o, 0);
        tick();
        chk("t4_ready", ready_o, 1);
        chk("t4_wvalid", word_valid_o, 0);
        chk("t4_done", done_o, 0);
        $display("txn single: words=%0d", wq.size());

        // overflow: 257 max products in one column
        clear_log();
        for (int i = 0; i < 257; i++) drive(1, P_ONE, 0, 0);
        chk("ovf_not_yet", ovf_o, 0);
        drive(1, 64'h0, 1, 1);
        chk("ovf_set", ovf_o, 1);
        set_idle();
        repeat (5) tick();
        chk("ovf_count", wq.size(), 2);
        chk("ovf_w0", wq_at(0), 32'hFFFFFEFF);
        chk("ovf_w1", wq_at(1), 32'hFFFFFFFF);
        chk("ovf_done_idx", done_idx, 1);
        chk("ovf_sticky", ovf_o, 1);
        $display("txn overflow: ovf=%0d words=%0d", ovf_o, wq.size());

        // inputs held while not ready are dropped; ovf clears on first accept
        clear_log();
        drive(1, 64'h1, 1, 1);
        chk("ovf_clear", ovf_o, 0);
        drive(1, 64'hDEAD, 0, 0);
        drive(1, 64'hDEAD, 0, 0);
        drive(1, 64'hDEAD, 0, 0);
        chk("drop_ready_back", ready_o, 1);
        drive(1, 64'h00000005_00000007, 1, 1);
        set_idle();
        repeat (5) tick();
        chk("drop_count", wq.size(), 4);
        chk("drop_w0", wq_at(0), 32'h00000001);
        chk("drop_w1", wq_at(1), 32'h00000000);
        chk("drop_w2", wq_at(2), 32'h00000007);
        chk("drop_w3", wq_at(3), 32'h00000005);
        chk("drop_done_cnt", done_cnt, 2);
        $display("txn drop: words=%0d", wq.size());

        // zeroize one cycle after an accepted op_last
        clear_log();
        drive(1, 64'h11111111_22222222, 1, 0);
        drive(1, 64'h33333333_44444444, 1, 1);
        set_idle();
        chk("zero_pre_wvalid", word_valid_o, 1);
        chk("zero_pre_word", word_o, 32'h22222222);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_wvalid", word_valid_o, 0);
        chk("zero_done", done_o, 0);
        chk("zero_word", word_o, 0);
        chk("zero_ovf", ovf_o, 0);
        chk("zero_ready", ready_o, 1);
        tick();
        chk("zero_wvalid2", word_valid_o, 0);
        chk("zero_done2", done_o, 0);
        drive(1, 64'h0000000A_0000000B, 1, 1);
        set_idle();
        repeat (5) tick();
        chk("zero_count", wq.size(), 3);
        chk("zero_w1", wq_at(1), 32'h0000000B);
        chk("zero_w2", wq_at(2), 32'h0000000A);
        chk("zero_done_cnt", done_cnt, 1);
        $display("txn zeroize: words=%0d", wq.size());

        // asynchronous reset mid-column
        drive(1, 64'h00000001_FFFFFFFF, 0, 0);
        set_idle();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_word", word_o, 0);
        chk("arst_wvalid", word_valid_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_done", done_o, 0);
        chk("arst_ovf", ovf_o, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        drive(1, 64'hCAFEBABE_00C0FFEE, 1, 1);
        set_idle();
        repeat (5) tick();
        chk("arst_count", wq.size(), 2);
        chk("arst_w0", wq_at(0), 32'h00C0FFEE);
        chk("arst_w1", wq_at(1), 32'hCAFEBABE);
        chk("arst_done_idx", done_idx, 1);
        $display("txn async_reset: words=%0d", wq.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
